// File: rtl/qam_frame_ctrl.sv
// Symbol-framing controller for the 16-QAM modulator: preamble, payload
// nibbles (high first), zero guard, with a per-frame byte limit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a byte; first preamble symbol loaded on exit
// ST_PRE   | loading the remaining preamble symbols
// ST_HI    | accepting a byte and loading its high nibble
// ST_LO    | loading the latched low nibble; decide end of payload
// ST_GUARD | loading zero guard symbols, then waiting for the last to drain
//
// frame_done/frame_trunc are registered: they pulse in the cycle after the
// edge on which the final symbol of the frame transfers, the same edge that
// advances frame_cnt.
module qam_frame_ctrl #(
   parameter int                PREAMBLE_LEN = 8,
   parameter int                GUARD_LEN    = 4,
   parameter int                MAX_BYTES    = 64,
   parameter logic signed [3:0] PRE_A        = 4'sh5,
   parameter logic signed [3:0] PRE_B        = -4'sh6
) (
   input  logic              axi_clk,
   input  logic              axi_rstn,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              sym_valid,
   output logic signed [3:0] sym_data,
   input  logic              sym_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_trunc,
   output logic [15:0]       frame_cnt
);

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  GUARD_N  = 8'(GUARD_LEN);
   localparam logic [15:0] MAX_N    = 16'(MAX_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_HI,
      ST_LO,
      ST_GUARD
   } state_t;

   state_t            state, state_nxt;
   logic              sym_valid_nxt;
   logic signed [3:0] sym_data_nxt;
   logic [7:0]        pre_cnt, pre_cnt_nxt;
   logic [15:0]       byte_cnt, byte_cnt_nxt;
   logic [7:0]        guard_cnt, guard_cnt_nxt;
   logic [3:0]        lo_nib, lo_nib_nxt;
   logic              last_q, last_nxt;
   logic              trunc_q, trunc_nxt;
   logic [15:0]       frame_cnt_nxt;
   logic              done_nxt;
   logic              trunc_pulse_nxt;
   logic              load;
   logic              xfer;

   // The output register may take a new symbol when empty or being drained.
   assign load = !sym_valid || sym_ready;
   assign xfer = sym_valid && sym_ready;
   assign busy = (state != ST_IDLE);

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge axi_clk) begin
      if (!axi_rstn) begin
         state       <= ST_IDLE;
         sym_valid   <= 1'b0;
         sym_data    <= 4'sd0;
         pre_cnt     <= '0;
         byte_cnt    <= '0;
         guard_cnt   <= '0;
         lo_nib      <= '0;
         last_q      <= 1'b0;
         trunc_q     <= 1'b0;
         frame_cnt   <= '0;
         frame_done  <= 1'b0;
         frame_trunc <= 1'b0;
      end else begin
         state       <= state_nxt;
         sym_valid   <= sym_valid_nxt;
         sym_data    <= sym_data_nxt;
         pre_cnt     <= pre_cnt_nxt;
         byte_cnt    <= byte_cnt_nxt;
         guard_cnt   <= guard_cnt_nxt;
         lo_nib      <= lo_nib_nxt;
         last_q      <= last_nxt;
         trunc_q     <= trunc_nxt;
         frame_cnt   <= frame_cnt_nxt;
         frame_done  <= done_nxt;
         frame_trunc <= trunc_pulse_nxt;
      end
   end

   // Next-state, symbol selection and counter updates.
   always_comb begin
      state_nxt       = state;
      sym_valid_nxt   = sym_valid;
      sym_data_nxt    = sym_data;
      pre_cnt_nxt     = pre_cnt;
      byte_cnt_nxt    = byte_cnt;
      guard_cnt_nxt   = guard_cnt;
      lo_nib_nxt      = lo_nib;
      last_nxt        = last_q;
      trunc_nxt       = trunc_q;
      frame_cnt_nxt   = frame_cnt;
      done_nxt        = 1'b0;
      trunc_pulse_nxt = 1'b0;
      s_ready         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (s_valid && load) begin
               sym_valid_nxt = 1'b1;
               sym_data_nxt  = PRE_A;
               pre_cnt_nxt   = 8'd1;
               state_nxt     = (PREAMBLE_LEN == 1) ? ST_HI : ST_PRE;
            end else if (load) begin
               sym_valid_nxt = 1'b0;
            end
         end

         ST_PRE: begin
            if (load) begin
               sym_valid_nxt = 1'b1;
               sym_data_nxt  = pre_cnt[0] ? PRE_B : PRE_A;
               pre_cnt_nxt   = pre_cnt + 8'd1;
               if (pre_cnt == PRE_LAST) begin
                  state_nxt = ST_HI;
               end
            end
         end

         ST_HI: begin
            s_ready = load;
            if (load) begin
               if (s_valid) begin
                  sym_valid_nxt = 1'b1;
                  sym_data_nxt  = s_data[7:4];
                  lo_nib_nxt    = s_data[3:0];
                  last_nxt      = s_last;
                  byte_cnt_nxt  = byte_cnt + 16'd1;
                  state_nxt     = ST_LO;
               end else begin
                  // Source underrun: leave a gap rather than stall the frame.
                  sym_valid_nxt = 1'b0;
               end
            end
         end

         ST_LO: begin
            if (load) begin
               sym_valid_nxt = 1'b1;
               sym_data_nxt  = lo_nib;
               if (last_q || (byte_cnt == MAX_N)) begin
                  guard_cnt_nxt = '0;
                  trunc_nxt     = !last_q;
                  state_nxt     = ST_GUARD;
               end else begin
                  state_nxt = ST_HI;
               end
            end
         end

         ST_GUARD: begin
            // With GUARD_LEN == 0 this state only waits for the low nibble.
            if (guard_cnt != GUARD_N) begin
               if (load) begin
                  sym_valid_nxt = 1'b1;
                  sym_data_nxt  = 4'sd0;
                  guard_cnt_nxt = guard_cnt + 8'd1;
               end
            end else if (xfer) begin
               sym_valid_nxt   = 1'b0;
               done_nxt        = 1'b1;
               trunc_pulse_nxt = trunc_q;
               frame_cnt_nxt   = frame_cnt + 16'd1;
               byte_cnt_nxt    = '0;
               trunc_nxt       = 1'b0;
               last_nxt        = 1'b0;
               state_nxt       = ST_IDLE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
